// File: rtl/rx_serial_align_pkg.sv
// Shared PHY constants for the serial link: the idle/alignment byte, the
// number of consecutive aligned idle bytes needed for lock, and the receive
// alignment state encoding. The transmit-side serializer uses the same package.
package rx_serial_align_pkg;

  localparam logic [7:0]  COMMA_DEFAULT    = 8'hBC;
  localparam int unsigned BC_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } align_state_t;

endpackage

// File: rtl/rx_serial_align_shift8.sv
// Bit-rate shift register for the receive aligner.
//   clk_32f     : bit-rate clock, rising edge
//   reset_L     : asynchronous active-low reset, clears the history to zero
//   data_in     : serial bit, MSB of each byte first
//   sr_next     : the register contents after this edge, {sr[6:0], data_in}
//   comma_match : sr_next equals COMMA
// COMMA must be non-zero so the cleared register never looks like an idle byte.
module rx_shift8
  import rx_serial_align_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] sr_next,
  output logic       comma_match
);

  // The oldest bit of the 8-bit register is shifted out without ever being
  // read, so only the seven bits that feed sr_next are stored.
  logic [6:0] sr_hist;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr_hist <= '0;
    end else begin
      sr_hist <= sr_next[6:0];
    end
  end

  assign sr_next     = {sr_hist, data_in};
  assign comma_match = (sr_next == COMMA);

endmodule

// File: rtl/rx_serial_align.sv
// Serial receive byte aligner.
// Hunts bit by bit for COMMA, then requires BC_COUNT consecutive COMMA bytes on
// the same byte grid before locking. Once locked (sticky until reset), every
// non-COMMA byte is presented on data_out with valid_out high for one byte
// period; a COMMA byte drops valid_out and leaves data_out unchanged.
//   clk_32f   : bit-rate clock, rising edge
//   reset_L   : asynchronous active-low reset
//   data_in   : serial bit, MSB of each byte first
//   data_out  : last received non-COMMA byte, registered
//   valid_out : data_out holds a byte received in the current byte period
//   active    : byte alignment is locked
module rx_serial_align
  import rx_serial_align_pkg::*;
#(
  parameter logic [7:0]  COMMA    = COMMA_DEFAULT,
  parameter int unsigned BC_COUNT = BC_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned    CW      = $clog2(BC_COUNT + 1);
  localparam logic [CW-1:0]  BC_LAST = CW'(BC_COUNT - 1);

  align_state_t  state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [CW-1:0] bc_cnt, bc_cnt_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;
  logic          active_nxt;
  logic          boundary;
  logic [7:0]    sr_next;
  logic          comma_match;

  rx_shift8 #(.COMMA(COMMA)) u_shift8 (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .sr_next     (sr_next),
    .comma_match (comma_match)
  );

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEARCH;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      bc_cnt    <= bc_cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      active    <= active_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bc_cnt_nxt  = bc_cnt;
    data_nxt    = data_out;
    valid_nxt   = valid_out;
    active_nxt  = active;
    // bit_cnt==7 means this edge samples the last bit of a byte on the grid.
    boundary    = (bit_cnt == 3'd7);

    if (state != SEARCH) begin
      bit_cnt_nxt = bit_cnt + 3'd1;
    end

    unique case (state)
      SEARCH: begin
        if (comma_match) begin
          // The COMMA found by the hunt is the first of the group and fixes
          // the byte grid: the next boundary is eight edges from now.
          bc_cnt_nxt  = CW'(1);
          bit_cnt_nxt = '0;
          if (BC_COUNT <= 1) begin
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt = COUNT;
          end
        end else begin
          bc_cnt_nxt = '0;
        end
      end
      COUNT: begin
        if (boundary) begin
          if (comma_match) begin
            bc_cnt_nxt = bc_cnt + CW'(1);
            if (bc_cnt == BC_LAST) begin
              state_nxt  = ACTIVE;
              active_nxt = 1'b1;
            end
          end else begin
            state_nxt  = SEARCH;
            bc_cnt_nxt = '0;
          end
        end
      end
      ACTIVE: begin
        // Only grid-aligned bytes are examined, so COMMA-like bit patterns
        // straddling two bytes never disturb the lock.
        if (boundary) begin
          if (comma_match) begin
            valid_nxt = 1'b0;
          end else begin
            data_nxt  = sr_next;
            valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = SEARCH;
      end
    endcase
  end

endmodule
